// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage PC unit.
package pc_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_op_t;

    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } pc_state_t;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;
    localparam logic [31:0] DEF_ADDR_LO  = 32'h0000_3000;
    localparam logic [31:0] DEF_ADDR_HI  = 32'h0000_6FFC;

    localparam logic [4:0]  EXC_ADEL     = 5'd4;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC target selection for SEQ / BR / J / JR requests from D.
module npc_calc
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      npc_op,
    input  logic            br_taken,
    input  logic [15:0]     imm16,
    input  logic [25:0]     addr26,
    input  logic [XLEN-1:0] pc_f,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] ra,
    output logic [XLEN-1:0] npc
);

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] br_off;

    assign seq_pc = pc_f + XLEN'(4);
    assign br_off = {{(XLEN-18){imm16[15]}}, imm16, 2'b00};

    always_comb begin
        npc = seq_pc;
        case (npc_op_t'(npc_op))
            NPC_SEQ: npc = seq_pc;
            NPC_BR:  npc = br_taken ? (pc_d + XLEN'(4) + br_off) : seq_pc;
            NPC_J:   npc = {pc_d[XLEN-1:28], addr26, 2'b00};
            NPC_JR:  npc = ra;
            default: npc = seq_pc;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC register, imem valid/ack handshake and redirect capture (FETCH/DROP FSM).
// Optional fetch address check enabled by defining PC_ADDR_CHECK_EN.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
    parameter logic [XLEN-1:0] EXC_PC   = XLEN'(DEF_EXC_PC),
    parameter logic [XLEN-1:0] ADDR_LO  = XLEN'(DEF_ADDR_LO),
    parameter logic [XLEN-1:0] ADDR_HI  = XLEN'(DEF_ADDR_HI)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_f,
    input  logic [1:0]      npc_op,
    input  logic            br_taken,
    input  logic [15:0]     imm16,
    input  logic [25:0]     addr26,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] ra,
    input  logic            exc_req,
    input  logic            eret_req,
    input  logic [XLEN-1:0] epc,
    input  logic            fetch_ack,
    output logic [XLEN-1:0] pc_f,
    output logic            fetch_req,
    output logic            inst_valid_f,
    output logic            f_busy,
    output logic            adel_f
);

    pc_state_t       state, state_nx;
    logic [XLEN-1:0] pc_q, pc_nx;
    logic [XLEN-1:0] redir_q, redir_nx;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] redir_tgt;
    logic            redir;
    logic            adel;
    logic            ack;

    npc_calc #(.XLEN(XLEN)) u_npc (
        .npc_op   (npc_op),
        .br_taken (br_taken),
        .imm16    (imm16),
        .addr26   (addr26),
        .pc_f     (pc_q),
        .pc_d     (pc_d),
        .ra       (ra),
        .npc      (npc)
    );

    assign redir     = exc_req | eret_req;
    assign redir_tgt = exc_req ? EXC_PC : epc;

`ifdef PC_ADDR_CHECK_EN
    assign adel = !reset && ((pc_q[1:0] != 2'b00) || (pc_q < ADDR_LO) || (pc_q > ADDR_HI));
`else
    assign adel = 1'b0;
`endif

    // A faulting address is never sent to imem, so it completes as if acked.
    assign ack = fetch_ack | adel;

    always_comb begin
        state_nx     = state;
        pc_nx        = pc_q;
        redir_nx     = redir_q;
        inst_valid_f = 1'b0;
        f_busy       = 1'b0;
        if (!reset) begin
            f_busy = !ack;
            case (state)
                FETCH: begin
                    if (redir) begin
                        if (ack) begin
                            pc_nx = redir_tgt;
                        end else begin
                            redir_nx = redir_tgt;
                            state_nx = DROP;
                        end
                    end else if (ack && !stall_f) begin
                        pc_nx        = npc;
                        inst_valid_f = !adel;
                    end
                end
                DROP: begin
                    // A newer CP0 request replaces the pending one; stall_f does not matter here.
                    if (redir) redir_nx = redir_tgt;
                    if (ack) begin
                        pc_nx    = redir ? redir_tgt : redir_q;
                        state_nx = FETCH;
                    end
                end
                default: state_nx = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state   <= FETCH;
            redir_q <= '0;
        end else begin
            pc_q    <= pc_nx;
            state   <= state_nx;
            redir_q <= redir_nx;
        end
    end

    assign pc_f      = pc_q;
    assign fetch_req = !reset && !adel;
    assign adel_f    = adel;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus randomized check of pc_fetch_unit against a behavioural model of the PC rules.
module tb_pc_fetch_unit;
    import pc_pkg::*;

    logic        clk = 1'b1;
    logic        reset, stall_f, br_taken, exc_req, eret_req, fetch_ack;
    logic [1:0]  npc_op;
    logic [15:0] imm16;
    logic [25:0] addr26;
    logic [31:0] pc_d, ra, epc;
    logic [31:0] pc_f;
    logic        fetch_req, inst_valid_f, f_busy, adel_f;

    pc_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .stall_f      (stall_f),
        .npc_op       (npc_op),
        .br_taken     (br_taken),
        .imm16        (imm16),
        .addr26       (addr26),
        .pc_d         (pc_d),
        .ra           (ra),
        .exc_req      (exc_req),
        .eret_req     (eret_req),
        .epc          (epc),
        .fetch_ack    (fetch_ack),
        .pc_f         (pc_f),
        .fetch_req    (fetch_req),
        .inst_valid_f (inst_valid_f),
        .f_busy       (f_busy),
        .adel_f       (adel_f)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] m_pc    = 32'h3000;
    logic [31:0] m_redir = 32'h0;
    bit          m_pend  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] m_target();
        case (npc_op)
            2'd0:    return m_pc + 4;
            2'd1:    return br_taken ? pc_d + 4 + int'($signed(imm16)) * 4 : m_pc + 4;
            2'd2:    return (pc_d & 32'hF000_0000) | (32'(addr26) * 4);
            default: return ra;
        endcase
    endfunction

    function automatic bit m_bad_addr(input logic [31:0] a);
        bit bad = 1'b0;
`ifdef PC_ADDR_CHECK_EN
        bad = (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
`endif
        return bad;
    endfunction

    // One clock: check outputs for the current inputs, then advance the model.
    task automatic step();
        bit          adel, done;
        logic [31:0] cp0_tgt, n_pc, n_redir;
        bit          n_pend;
        adel = !reset && m_bad_addr(m_pc);
        done = fetch_ack || adel;
        @(negedge clk);
        chk("pc_f", pc_f, m_pc);
        chk("fetch_req", 32'(fetch_req), 32'(!reset && !adel));
        chk("f_busy", 32'(f_busy), 32'(!reset && !done));
        chk("inst_valid_f", 32'(inst_valid_f),
            32'(!reset && !m_pend && done && !exc_req && !eret_req && !stall_f && !adel));
        chk("adel_f", 32'(adel_f), 32'(adel));
        cp0_tgt = exc_req ? 32'h4180 : epc;
        n_pc = m_pc; n_redir = m_redir; n_pend = m_pend;
        if (reset) begin
            n_pc = 32'h3000; n_redir = 0; n_pend = 0;
        end else if (!m_pend) begin
            if (exc_req || eret_req) begin
                if (done) n_pc = cp0_tgt;
                else begin n_pend = 1; n_redir = cp0_tgt; end
            end else if (done && !stall_f) n_pc = m_target();
        end else begin
            if (exc_req || eret_req) n_redir = cp0_tgt;
            if (done) begin n_pc = n_redir; n_pend = 0; end
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_redir = n_redir; m_pend = n_pend;
    endtask

    task automatic idle();
        reset = 0; stall_f = 0; npc_op = 2'd0; br_taken = 0; imm16 = 0; addr26 = 0;
        pc_d = 32'h3000; ra = 32'h3000; epc = 32'h3000; exc_req = 0; eret_req = 0; fetch_ack = 1;
    endtask

    initial begin
        idle();
        reset = 1;
        @(posedge clk);
        #1;
        step();
        step();
        chk("rst_fetch_req", 32'(fetch_req), 32'd0);
        reset = 0;
        step(); chk("seq1", pc_f, 32'h3004);
        step(); chk("seq2", pc_f, 32'h3008);

        npc_op = 2'd1; br_taken = 1; pc_d = 32'h3010; imm16 = 16'hFFFC;
        step(); chk("br_taken", pc_f, 32'h3004);
        npc_op = 2'd3; ra = 32'h3014;
        step(); chk("jr_3014", pc_f, 32'h3014);
        npc_op = 2'd1; br_taken = 0;
        step(); chk("br_not_taken", pc_f, 32'h3018);
        npc_op = 2'd2; pc_d = 32'h3020; addr26 = 26'hC40;
        step(); chk("j", pc_f, 32'h3100);
        npc_op = 2'd3; ra = 32'h3400;
        step(); chk("jr", pc_f, 32'h3400);
        npc_op = 2'd0; stall_f = 1;
        step(); chk("stall_hold", pc_f, 32'h3400);
        stall_f = 0;

        fetch_ack = 0; exc_req = 1;
        step();
        exc_req = 0;
        step();
        step();
        chk("drop_state", 32'(dut.state), 32'(DROP));
        chk("drop_busy", 32'(f_busy), 32'd1);
        fetch_ack = 1;
        chk("drop_ack_valid", 32'(inst_valid_f), 32'd0);
        step(); chk("exc_redirect", pc_f, 32'h4180);

        exc_req = 1; eret_req = 1; epc = 32'h3050;
        step(); chk("exc_beats_eret", pc_f, 32'h4180);
        exc_req = 0;
        step(); chk("eret", pc_f, 32'h3050);
        eret_req = 0;

        fetch_ack = 0; exc_req = 1;
        step();
        exc_req = 0; reset = 1;
        step(); chk("reset_in_drop", pc_f, 32'h3000);
        reset = 0; fetch_ack = 1;
        step(); chk("redirect_lost", pc_f, 32'h3004);

        npc_op = 2'd3; ra = 32'h3002;
        step();
`ifdef PC_ADDR_CHECK_EN
        chk("adel_misaligned", 32'(adel_f), 32'd1);
        chk("adel_no_req", 32'(fetch_req), 32'd0);
        chk("adel_no_valid", 32'(inst_valid_f), 32'd0);
        npc_op = 2'd0; exc_req = 1;
        step(); chk("adel_exc", pc_f, 32'h4180);
        exc_req = 0; npc_op = 2'd3; ra = 32'h7000;
        step();
        chk("adel_range", 32'(adel_f), 32'd1);
        npc_op = 2'd0; exc_req = 1;
        step();
        exc_req = 0;
`else
        chk("adel_off", 32'(adel_f), 32'd0);
        npc_op = 2'd3; ra = 32'h7000;
        step();
        chk("adel_off_range", 32'(adel_f), 32'd0);
        npc_op = 2'd0; exc_req = 1;
        step();
        exc_req = 0;
`endif

        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 99) < 3);
            stall_f   = ($urandom_range(0, 99) < 20);
            fetch_ack = ($urandom_range(0, 99) < 70);
            exc_req   = ($urandom_range(0, 99) < 8);
            eret_req  = ($urandom_range(0, 99) < 8);
            npc_op    = 2'($urandom_range(0, 3));
            br_taken  = 1'($urandom);
            imm16     = 16'($urandom_range(0, 64)) - 16'd32;
            addr26    = 26'h0C00 + 26'($urandom_range(0, 255));
            pc_d      = 32'h3000 + 32'($urandom_range(64, 2047)) * 4;
            ra        = 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
            epc       = 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised next-generation PC unit for the fetch stage of the 5-stage MIPS pipeline with exceptions. It owns the fetch PC register and computes the next PC from sequential, branch, jump and jump-register requests out of D. It redirects to the exception handler or EPC on requests from the CP0/M stage. It adds a valid/ack handshake to instruction memory so multi-cycle fetches are supported. Redirects that arrive while a fetch is outstanding are captured, and the stale instruction is dropped.

## Interface
- `XLEN`, 32: PC / data width.
- `RESET_PC`, 32'h0000_3000: PC loaded by reset.
- `EXC_PC`, 32'h0000_4180: exception handler entry.
- `ADDR_LO`, 32'h0000_3000: lowest legal fetch address; used only with the check macro.
- `ADDR_HI`, 32'h0000_6FFC: highest legal fetch address; used only with the check macro.
- `clk`  in  1  single clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall_f`  in  1  hazard-unit freeze of F.
- `npc_op`  in  2  D-stage request: SEQ=0, BR=1, J=2, JR=3.
- `br_taken`  in  1  branch comparison result from D.
- `imm16`  in  16  branch offset.
- `addr26`  in  26  jump index.
- `pc_d`  in  XLEN  PC of the instruction in D.
- `ra`  in  XLEN  forwarded GPR value for JR.
- `exc_req`  in  1  exception-entry request.
- `eret_req`  in  1  ERET request.
- `epc`  in  XLEN  return address for ERET.
- `fetch_ack`  in  1  imem has data for `pc_f` this cycle.
- `pc_f`  out  XLEN  current fetch PC (registered).
- `fetch_req`  out  1  request imem read at `pc_f`.
- `inst_valid_f`  out  1  the instruction returned this cycle goes to D.
- `f_busy`  out  1  fetch outstanding (ack low); the hazard unit stalls D on it.
- `adel_f`  out  1  fetch address error (ExcCode 4).

## Operation
- Target arithmetic is modulo 2^XLEN:
  - SEQ: `pc_f+4`.
  - BR: `pc_d+4+(sext(imm16)<<2)` if `br_taken`, else `pc_f+4`.
  - J: `{pc_d[XLEN-1:28],addr26,2'b00}`.
  - JR: `ra`.
- Per-cycle update priority is: reset > exc_req > eret_req > stall_f > npc_op.
- FSM states:
  - FETCH: normal operation.
  - DROP: a redirect is pending and the in-flight fetch will be discarded.
- FETCH state:
  - `exc_req`/`eret_req` with `fetch_ack`=1: load `EXC_PC`/`epc` into `pc_f`; `inst_valid_f`=0.
  - `exc_req`/`eret_req` with `fetch_ack`=0: latch the target into `redir_pc`; go to DROP.
  - Otherwise, with `fetch_ack`=1 and `stall_f`=0: `pc_f`<=target; `inst_valid_f`=1.
  - With `fetch_ack`=1 and `stall_f`=1: `pc_f` held; `inst_valid_f`=0.
  - With `fetch_ack`=0: `pc_f` held; `f_busy`=1.
- DROP state:
  - A further `exc_req`/`eret_req` overwrites `redir_pc`, with exc winning when both arrive together.
  - On `fetch_ack`: `pc_f`<=`redir_pc`, `inst_valid_f`=0, go to FETCH. `stall_f` is ignored.
  - `f_busy`=1 until the ack.
- D-stage redirects are never captured. D is stalled while `f_busy`=1, so they stay presented until the fetch completes.
- `fetch_req`=!reset && !`adel_f`. It is held high until acked; the request address must not change while un-acked.
- Reset values: `pc_f`=RESET_PC, state FETCH, `redir_pc`=0, `inst_valid_f`=0, `fetch_req`=0, `f_busy`=0, `adel_f`=0.
- Reset mid-DROP abandons the pending redirect; the next cycle fetches RESET_PC.

## Timing
- With `fetch_ack` tied to 1 the unit issues one PC per cycle with no bubbles. This is identical in timing to the single-cycle next-PC path.
- A redirect issued in cycle N appears on `pc_f` at cycle N+1 if acked in N.
- If the redirect is unacked, it appears one cycle after the ack cycle.
- `inst_valid_f` and `f_busy` are combinational from the state and `fetch_ack`.
- `pc_f` changes only on a clock edge.

## Configuration
- `PC_ADDR_CHECK_EN` defined:
  - `adel_f`=1 when `pc_f[1:0]`!=0 or `pc_f` is outside [ADDR_LO, ADDR_HI].
  - In that cycle `fetch_req`=0, the access is treated as acked, and `inst_valid_f`=0.
  - `pc_f` still advances per the normal rules, so an exception from downstream redirects it.
- Undefined: `adel_f` is tied 0 and every PC is requested.

## Structure
- Shared package `pc_pkg`:
  - `npc_op_t` enum (SEQ/BR/J/JR).
  - `pc_state_t` (FETCH/DROP).
  - Default RESET_PC/EXC_PC/ADDR_LO/ADDR_HI constants.
  - ExcCode constant ADEL=4.
- Sub-module `npc_calc`: combinational target selection and arithmetic. The top level holds the PC register, `redir_pc`, the FSM and the address check.

## Test plan
- Reset 2 cycles, then `fetch_ack`=1, `npc_op`=SEQ: `pc_f`=0x3000 during reset with `fetch_req`=0, then 0x3004 and 0x3008, with `inst_valid_f`=1 each cycle.
- BR with `br_taken`=1, `pc_d`=0x3010, `imm16`=0xFFFC: next `pc_f`=0x3004. Same inputs with `br_taken`=0 and `pc_f`=0x3014: next `pc_f`=0x3018.
- J with `pc_d`=0x3020, `addr26`=0xC40: next `pc_f`=0x3100. JR with `ra`=0x3400: next `pc_f`=0x3400. `stall_f`=1 with ack: `pc_f` held and `inst_valid_f`=0.
- `fetch_ack`=0 for 3 cycles with `exc_req` pulsed in cycle 1, then ack: `f_busy`=1 for 3 cycles, state DROP, `inst_valid_f`=0 on the ack cycle, `pc_f`=0x4180 next cycle.
- `eret_req` and `exc_req` in the same cycle with `epc`=0x3050: `pc_f`=0x4180. `eret_req` alone: `pc_f`=0x3050. Reset asserted during DROP: `pc_f`=0x3000 and the redirect is lost.
- With `PC_ADDR_CHECK_EN`, JR to `ra`=0x3002: `adel_f`=1, `fetch_req`=0, `inst_valid_f`=0. JR to 0x7000 also gives `adel_f`=1. Without the macro, `adel_f` stays 0.
